// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types and constants for the RV32I pipeline controller.
//               Holds the controller state enum, the forwarding select
//               encodings, the load result-select code and a forwarding
//               helper used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // The M stage holds the younger result, so it wins over W. x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m,
                                         input logic       we_m,
                                         input logic [4:0] rd_w,
                                         input logic       we_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0 && we_m && rs == rd_m) begin
      sel = FWD_M;
    end else if (rs != 5'd0 && we_w && rs == rd_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Hazard/sequencing bundle between the five-stage datapath and
//               the pipeline controller.
//   master : controller side - drives stalls, flushes and forward selects,
//            observes register indices and memory handshake.
//   slave  : datapath side - the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic [4:0] RdM;
  logic       RegWriteM;
  logic       MemReqM;
  logic       dmem_ready;
  logic [4:0] RdW;
  logic       RegWriteW;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    input  RdM, RegWriteM, MemReqM, dmem_ready, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE
  );

  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
    output RdM, RegWriteM, MemReqM, dmem_ready, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_mem_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_fsm
// Description : Controller state register plus data-memory wait/timeout
//               logic. Leaves BOOT when the top level signals boot_done,
//               freezes the pipeline while a memory access is outstanding and
//               locks into ERR after MEM_TIMEOUT unanswered wait cycles.
// Ports       : clk, reset (async, active-low), boot_done, mem_req,
//               dmem_ready -> state, freeze, err
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_fsm
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  wire    clk,
  input  wire    reset,
  input  wire    boot_done,
  input  wire    mem_req,
  input  wire    dmem_ready,
  output state_e state,
  output logic   freeze,
  output logic   err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    case (state_q)
      BOOT: begin
        if (boot_done) state_d = RUN;
      end
      RUN: begin
        // The requesting cycle itself is already frozen.
        if (mem_req && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        // The ready cycle is not frozen; normal hazard logic takes over.
        if (dmem_ready) begin
          state_d = RUN;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d == CNT_W'(MEM_TIMEOUT)) state_d = ERR;
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign state = state_q;
  assign err   = (state_q == ERR);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard, forwarding and sequencing controller for the
//               five-stage RV32I core. Drives pipeline stall/flush enables,
//               execute-stage forwarding selects, boot sequencing and the
//               data-memory freeze.
// Ports       : clk, reset (async, active-low)
//               pif       - pipeline_ctrl_if.master hazard bundle
//               mem_err   - sticky data-memory timeout flag
//               stall_cycles, flush_count - performance counters
// Config      : PIPELINE_CTRL_PERF_EN enables the performance counters;
//               otherwise both counter ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input  wire                clk,
  input  wire                reset,
  pipeline_ctrl_if.master    pif,
  output logic               mem_err,
  output logic [PERF_W-1:0]  stall_cycles,
  output logic [PERF_W-1:0]  flush_count
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_e             state;
  logic               freeze;
  logic               boot_done;
  logic               lw_stall;
  logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;

  assign boot_done = (state == BOOT) && (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1));

  always_comb begin
    boot_cnt_d = boot_cnt_q;
    if (state == BOOT && !boot_done) boot_cnt_d = boot_cnt_q + BOOT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) boot_cnt_q <= '0;
    else        boot_cnt_q <= boot_cnt_d;
  end

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk        (clk),
    .reset      (reset),
    .boot_done  (boot_done),
    .mem_req    (pif.MemReqM),
    .dmem_ready (pif.dmem_ready),
    .state      (state),
    .freeze     (freeze),
    .err        (mem_err)
  );

  // A taken branch squashes the dependent load consumer anyway, so no stall.
  assign lw_stall = (pif.ResultSrcE == RESULT_LOAD) && (pif.RdE != 5'd0) &&
                    ((pif.Rs1D == pif.RdE) || (pif.Rs2D == pif.RdE)) && !pif.PCSrcE;

  always_comb begin
    pif.ForwardAE = fwd_sel(pif.Rs1E, pif.RdM, pif.RegWriteM, pif.RdW, pif.RegWriteW);
    pif.ForwardBE = fwd_sel(pif.Rs2E, pif.RdM, pif.RegWriteM, pif.RdW, pif.RegWriteW);
    pif.StallF    = 1'b0;
    pif.StallD    = 1'b0;
    pif.StallE    = 1'b0;
    pif.StallM    = 1'b0;
    pif.FlushD    = 1'b0;
    pif.FlushE    = 1'b0;
    pif.FlushW    = 1'b0;
    if (state == BOOT) begin
      pif.StallF = 1'b1;
      pif.StallD = 1'b1;
      pif.FlushE = 1'b1;
    end else if (freeze) begin
      // Memory freeze overrides every hazard-driven stall or flush.
      pif.StallF = 1'b1;
      pif.StallD = 1'b1;
      pif.StallE = 1'b1;
      pif.StallM = 1'b1;
      pif.FlushW = 1'b1;
    end else begin
      pif.StallF = lw_stall;
      pif.StallD = lw_stall;
      pif.FlushD = pif.PCSrcE;
      pif.FlushE = lw_stall | pif.PCSrcE;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (state != BOOT && pif.StallF) stall_cycles_d = stall_cycles_q + PERF_W'(1);
    if (pif.FlushD)                  flush_count_d  = flush_count_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Directed scenarios
//               followed by randomized traffic, compared every cycle against
//               a cycle-count reference model of the controller behaviour.
// Config      : honours PIPELINE_CTRL_PERF_EN for counter expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int BOOT_CYCLES = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int PERF_W      = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_err;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  always #5 clk = ~clk;

  pipeline_ctrl_if pif();

  pipeline_ctrl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .PERF_W      (PERF_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pif          (pif),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // Reference model: remaining boot cycles, outstanding-wait bookkeeping,
  // sticky error and plain integer event counts.
  int          boot_left;
  bit          waiting;
  int          waited;
  bit          err;
  int unsigned sc;
  int unsigned fc;

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    boot_left = BOOT_CYCLES;
    waiting   = 1'b0;
    waited    = 0;
    err       = 1'b0;
    sc        = 0;
    fc        = 0;
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (pif.RegWriteM && pif.RdM == rs) return 2'b10;
    if (pif.RegWriteW && pif.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [6:0] exp_ctl();
    logic lw;
    if (!reset || boot_left > 0) return 7'b1100010;
    if (err || ((waiting || pif.MemReqM) && !pif.dmem_ready)) return 7'b1111001;
    lw = (pif.ResultSrcE == 2'b01) && (pif.RdE != 5'd0) &&
         (pif.Rs1D == pif.RdE || pif.Rs2D == pif.RdE) && !pif.PCSrcE;
    return {lw, lw, 2'b00, pif.PCSrcE, lw | pif.PCSrcE, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [6:0] ctl;
    ctl = {pif.StallF, pif.StallD, pif.StallE, pif.StallM, pif.FlushD, pif.FlushE, pif.FlushW};
    check("ctl", 64'(ctl), 64'(exp_ctl()));
    check("fwdA", 64'(pif.ForwardAE), 64'(fwd_ref(pif.Rs1E)));
    check("fwdB", 64'(pif.ForwardBE), 64'(fwd_ref(pif.Rs2E)));
    check("mem_err", 64'(mem_err), 64'(err));
`ifdef PIPELINE_CTRL_PERF_EN
    check("stall_cycles", 64'(stall_cycles), 64'(sc));
    check("flush_count", 64'(flush_count), 64'(fc));
`else
    check("stall_cycles", 64'(stall_cycles), 64'd0);
    check("flush_count", 64'(flush_count), 64'd0);
`endif
  endtask

  task automatic model_advance();
    logic [6:0] c;
    c = exp_ctl();
    if (boot_left > 0) begin
      boot_left--;
    end else begin
      if (c[6]) sc++;
      if (c[2]) fc++;
      if (err) begin
        // sticky until reset
      end else if (waiting) begin
        if (pif.dmem_ready) begin
          waiting = 1'b0;
        end else begin
          waited++;
          if (waited >= MEM_TIMEOUT) begin
            err     = 1'b1;
            waiting = 1'b0;
          end
        end
      end else if (pif.MemReqM && !pif.dmem_ready) begin
        waiting = 1'b1;
        waited  = 0;
      end
    end
  endtask

  // Entered at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    #1;
    if (reset) model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_reset();
    repeat (n) cycle();
    reset = 1'b1;
  endtask

  task automatic clear_in();
    pif.Rs1D = '0; pif.Rs2D = '0; pif.Rs1E = '0; pif.Rs2E = '0; pif.RdE = '0;
    pif.ResultSrcE = 2'b00; pif.PCSrcE = 1'b0;
    pif.RdM = '0; pif.RegWriteM = 1'b0; pif.MemReqM = 1'b0; pif.dmem_ready = 1'b1;
    pif.RdW = '0; pif.RegWriteW = 1'b0;
  endtask

  task automatic rand_in();
    pif.Rs1D = 5'($urandom_range(0, 3)); pif.Rs2D = 5'($urandom_range(0, 3));
    pif.Rs1E = 5'($urandom_range(0, 3)); pif.Rs2E = 5'($urandom_range(0, 3));
    pif.RdE  = 5'($urandom_range(0, 3)); pif.ResultSrcE = 2'($urandom_range(0, 3));
    pif.PCSrcE = ($urandom_range(0, 4) == 0);
    pif.RdM  = 5'($urandom_range(0, 3)); pif.RegWriteM = 1'($urandom_range(0, 1));
    pif.MemReqM = ($urandom_range(0, 3) == 0); pif.dmem_ready = ($urandom_range(0, 3) != 0);
    pif.RdW  = 5'($urandom_range(0, 3)); pif.RegWriteW = 1'($urandom_range(0, 1));
  endtask

  initial begin
    clear_in();
    // Reset held three cycles, then the boot window.
    do_reset(3);
    repeat (BOOT_CYCLES + 1) cycle();

    // Forwarding priority and the x0 exclusion.
    pif.Rs1E = 5'd5; pif.Rs2E = 5'd5; pif.RdM = 5'd5; pif.RegWriteM = 1'b1;
    pif.RdW = 5'd5; pif.RegWriteW = 1'b1;
    cycle();
    pif.Rs1E = 5'd0; cycle();
    pif.Rs2E = 5'd9; pif.RdW = 5'd9; cycle();
    clear_in();

    // Load-use, then the same with a taken branch.
    pif.ResultSrcE = 2'b01; pif.RdE = 5'd7; pif.Rs2D = 5'd7; cycle();
    pif.PCSrcE = 1'b1; cycle();
    clear_in(); cycle();

    // Memory wait of three cycles; branch during the wait must not flush D.
    pif.MemReqM = 1'b1; pif.dmem_ready = 1'b0; cycle();
    cycle();
    pif.PCSrcE = 1'b1; cycle();
    pif.PCSrcE = 1'b0; pif.dmem_ready = 1'b1; cycle();
    clear_in(); cycle();

    // Timeout into ERR, sticky, then asynchronous reset out of it.
    pif.MemReqM = 1'b1; pif.dmem_ready = 1'b0;
    repeat (1 + MEM_TIMEOUT) cycle();
    clear_in();
    repeat (3) cycle();
    check("err_sticky", 64'(mem_err), 64'd1);
    do_reset(2);
    repeat (BOOT_CYCLES) cycle();

    // One load-use stall plus one taken branch after boot.
    pif.ResultSrcE = 2'b01; pif.RdE = 5'd3; pif.Rs1D = 5'd3; cycle();
    clear_in(); pif.PCSrcE = 1'b1; cycle();
    clear_in(); cycle();
`ifdef PIPELINE_CTRL_PERF_EN
    check("perf_stalls", 64'(stall_cycles), 64'd1);
    check("perf_flushes", 64'(flush_count), 64'd1);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 500; i++) begin
      rand_in();
      if ($urandom_range(0, 59) == 0) do_reset(2);
      else                           cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard, forwarding and pipeline-sequencing controller for the five-stage RV32I core. It sits beside the F/D/E/M/W pipeline registers and drives their stall and flush enables. It drives the execute-stage operand forwarding selects. It also runs a small state machine that sequences boot-up and freezes the pipeline while a variable-latency data memory completes an access.

## Interface
Parameters:
- BOOT_CYCLES, 4: cycles after reset release during which fetch/decode are held stalled and flushed
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before a memory error is declared
- PERF_W, 32: width of the performance counters

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- Rs1D, Rs2D  input  5  decode-stage source registers
- Rs1E, Rs2E, RdE  input  5  execute-stage sources/destination
- ResultSrcE  input  2  execute result select; 2'b01 = load
- PCSrcE  input  1  taken branch or jump resolved in E
- RdM  input  5; RegWriteM  input  1  memory-stage writeback info
- MemReqM  input  1  load/store present in M
- dmem_ready  input  1  data memory completes the access this cycle
- RdW  input  5; RegWriteW  input  1  writeback-stage info
- StallF, StallD, StallE, StallM  output  1  hold the respective pipeline register
- FlushD, FlushE, FlushW  output  1  clear the respective pipeline register (a bubble)
- ForwardAE, ForwardBE  output  2  operand select: 00 register file, 01 W result, 10 M ALU result
- mem_err  output  1  sticky data-memory timeout flag
- stall_cycles, flush_count  output  PERF_W  performance counters

## Operation
- States: BOOT, RUN, MEM_WAIT, ERR.
- BOOT:
  - StallF=StallD=1, FlushE=1, all other controls 0.
  - A counter runs from 0 to BOOT_CYCLES-1, then the state moves to RUN.
- RUN:
  - Forwarding for ForwardAE (same rule for ForwardBE with Rs2E):
    - 10 if Rs1E!=0, RegWriteM=1 and Rs1E==RdM.
    - Otherwise 01 if Rs1E!=0, RegWriteW=1 and Rs1E==RdW.
    - Otherwise 00.
    - Forwarding is evaluated in every state.
  - lwStall = ResultSrcE==01, RdE!=0, (Rs1D==RdE or Rs2D==RdE), and PCSrcE=0.
  - StallF=StallD=lwStall.
  - FlushD=PCSrcE.
  - FlushE=lwStall|PCSrcE.
- Memory wait:
  - In RUN, MemReqM=1 with dmem_ready=0 goes to MEM_WAIT. It also combinationally asserts StallF/D/E/M=1 and FlushW=1 that same cycle.
  - In this case FlushD, FlushE and lwStall are suppressed; the memory freeze has top priority.
- MEM_WAIT:
  - Same freeze outputs as above.
  - The wait counter increments each cycle.
  - dmem_ready=1 returns the state to RUN; that cycle carries no freeze, and the normal RUN equations apply.
  - If the counter reaches MEM_TIMEOUT, the state moves to ERR.
- ERR: mem_err=1, all stalls 1, FlushW=1. Only reset exits ERR.
- Wait counter width is clog2(MEM_TIMEOUT+1). The counter clears on entry to MEM_WAIT.

## Timing
- All stall/flush/forward outputs are combinational from the inputs and the current state, with zero latency.
- The state and counters update on the rising edge of clk.
- While reset=0, all outputs hold their BOOT-state values:
  - state=BOOT, both counters 0.
  - StallF=StallD=FlushE=1.
  - All other stalls and flushes 0; Forward* follow the inputs.
  - mem_err=0; stall_cycles=flush_count=0.
- The first RUN cycle is cycle BOOT_CYCLES after reset deassertion.
- Reset asserted in MEM_WAIT or ERR returns to BOOT immediately (asynchronous).
- A MemReqM with dmem_ready=1 in the same cycle causes no stall.

## Configuration
- PIPELINE_CTRL_PERF_EN defined:
  - stall_cycles increments on every cycle with StallF=1 in RUN, MEM_WAIT or ERR.
  - flush_count increments on every cycle with FlushD=1.
  - Both counters wrap at 2^PERF_W.
- Not defined: both ports remain and are tied to 0, and no counter flops are generated.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (BOOT, RUN, MEM_WAIT, ERR);
  - forwarding constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RESULT_LOAD=2'b01.
- The memory-wait and timeout logic lives in one sub-module, mem_wait_fsm. It outputs a freeze flag and an error flag; the top level owns the BOOT sequencing and the hazard equations.

## Test plan
- Reset low 3 cycles, then release with BOOT_CYCLES=4 -> StallF=1 for cycles 0-3 after release, RUN and StallF=0 from cycle 4.
- Rs1E=5, RdM=5, RegWriteM=1, and also RdW=5, RegWriteW=1 -> ForwardAE=10. Rs1E=0 with matches -> ForwardAE=00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. The same stimulus with PCSrcE=1 gives StallF=0, FlushD=FlushE=1.
- MemReqM=1, dmem_ready low for 3 cycles -> StallF/D/E/M=1 and FlushW=1 for 3 cycles, all 0 on the ready cycle. With PCSrcE=1 during the wait, FlushD stays 0.
- dmem_ready held low, MEM_TIMEOUT=8 -> ERR after 8 wait cycles, mem_err=1 sticky. Reset low -> mem_err=0 and state BOOT.
- With PIPELINE_CTRL_PERF_EN, one load-use stall plus one taken branch -> stall_cycles=1 and flush_count=1 (boot cycles excluded).
